spi_receive_unpack: RTL and testbench

SPI_RECEIVE_UNPACK -- requirements
Module: spi_receive_unpack

---
 rtl/spi_receive_unpack.sv | 177 +++++++++++++++++
 tb/tb_spi_receive_unpack.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_receive_unpack.sv
// rtl/spi_receive_unpack.sv - SPI multi-line receiver that unpacks each packet into a pixel stream
// Lines are shifted MSB first; a completed packet is replayed one pixel per cycle with raster position.
module spi_receive_unpack #(
   parameter int DATA_WIDTH = 16,
   parameter int LINES      = 6,
   parameter int HRES       = 640,
   parameter int VRES       = 360
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic [LINES-1:0]      chip_data_in,
   input  logic                  chip_clk_in,
   input  logic                  chip_sel_in,
   output logic                  pixel_valid_out,
   output logic [DATA_WIDTH-1:0] pixel_data_out,
   output logic [9:0]            hcount_out,
   output logic [8:0]            vcount_out,
   output logic                  packet_error_out,
   output logic                  overflow_out
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam int IW = (LINES > 1) ? $clog2(LINES) : 1;
   localparam logic [CW-1:0] BIT_LAST = CW'(DATA_WIDTH - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(LINES - 1);
   localparam logic [9:0]    H_LAST   = 10'(HRES - 1);
   localparam logic [8:0]    V_LAST   = 9'(VRES - 1);

   typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;
   typedef enum logic {EM_IDLE, EM_EMIT} em_state_t;

   logic [1:0]       clk_sync;
   logic [1:0]       cs_sync;
   logic [LINES-1:0] data_s1;
   logic [LINES-1:0] data_s2;
   logic             clk_prev;
   logic [1:0]       fill;
   logic             armed;
   logic             strobe;
   logic             cs_s;

   rx_state_t        rx_state, rx_next;
   logic [CW-1:0]    bit_cnt;
   logic             shift_en;
   logic             complete;
   logic [DATA_WIDTH-2:0] sh        [LINES];
   logic [DATA_WIDTH-1:0] next_word [LINES];
   logic [DATA_WIDTH-1:0] pkt_buf   [LINES];

   em_state_t        em_state, em_next;
   logic [IW-1:0]    em_idx;
   logic             load;
   logic             idx_last;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         clk_sync <= 2'b00;
         cs_sync  <= 2'b11;
         data_s1  <= '0;
         data_s2  <= '0;
         clk_prev <= 1'b0;
         fill     <= 2'b00;
         armed    <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], chip_clk_in};
         cs_sync  <= {cs_sync[0], chip_sel_in};
         data_s1  <= chip_data_in;
         data_s2  <= data_s1;
         clk_prev <= clk_sync[1];
         fill     <= {fill[0], 1'b1};
         // Arm only once a real (post-reset) high cs has reached the synchronizer output.
         if (fill[1] && cs_sync[1]) armed <= 1'b1;
      end
   end

   assign strobe = clk_sync[1] & ~clk_prev;
   assign cs_s   = cs_sync[1];

   always_comb begin
      rx_next          = rx_state;
      packet_error_out = 1'b0;
      shift_en         = 1'b0;
      complete         = 1'b0;
      case (rx_state)
         RX_IDLE: if (armed && !cs_s) rx_next = RX_SHIFT;
         RX_SHIFT: begin
            if (cs_s) begin
               rx_next          = RX_IDLE;
               packet_error_out = (bit_cnt != '0);
            end else if (strobe) begin
               shift_en = 1'b1;
               complete = (bit_cnt == BIT_LAST);
            end
         end
         default: rx_next = RX_IDLE;
      endcase
   end

   always_comb begin
      for (int k = 0; k < LINES; k++) next_word[k] = {sh[k], data_s2[k]};
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         rx_state <= RX_IDLE;
         bit_cnt  <= '0;
      end else begin
         rx_state <= rx_next;
         if (complete || rx_state != RX_SHIFT || cs_s) bit_cnt <= '0;
         else if (shift_en) bit_cnt <= bit_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk_in) begin
      if (shift_en) begin
         for (int k = 0; k < LINES; k++) sh[k] <= next_word[k][DATA_WIDTH-2:0];
      end
      if (load) begin
         for (int k = 0; k < LINES; k++) pkt_buf[k] <= next_word[k];
      end
   end

   assign idx_last = (em_idx == IDX_LAST);

   // A completion on the final emit cycle chains straight into a new packet.
   always_comb begin
      em_next         = em_state;
      load            = 1'b0;
      overflow_out    = 1'b0;
      pixel_valid_out = 1'b0;
      case (em_state)
         EM_IDLE: begin
            if (complete) begin
               load    = 1'b1;
               em_next = EM_EMIT;
            end
         end
         EM_EMIT: begin
            pixel_valid_out = 1'b1;
            if (idx_last) begin
               if (complete) load = 1'b1;
               else em_next = EM_IDLE;
            end else if (complete) begin
               overflow_out = 1'b1;
            end
         end
         default: em_next = EM_IDLE;
      endcase
   end

   always_comb begin
      pixel_data_out = '0;
      if (pixel_valid_out) pixel_data_out = pkt_buf[em_idx];
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         em_state   <= EM_IDLE;
         em_idx     <= '0;
         hcount_out <= '0;
         vcount_out <= '0;
      end else begin
         em_state <= em_next;
         if (load || idx_last) em_idx <= '0;
         else if (em_state == EM_EMIT) em_idx <= em_idx + 1'b1;
         if (pixel_valid_out) begin
            if (hcount_out == H_LAST) begin
               hcount_out <= '0;
               vcount_out <= (vcount_out == V_LAST) ? '0 : vcount_out + 9'd1;
            end else begin
               hcount_out <= hcount_out + 10'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_receive_unpack.sv
// tb/tb_spi_receive_unpack.sv - scoreboard bench for spi_receive_unpack
// u_main uses a small raster to reach frame wrap; u_fast uses 2-bit words to force emitter collisions.
module tb_spi_receive_unpack;

   localparam int H1 = 12;
   localparam int V1 = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, rst2;
   logic [5:0]  data1, data2;
   logic        dclk1, dclk2, cs1, cs2;
   logic        valid1, valid2, err1, err2, ovf1, ovf2;
   logic [15:0] pix1;
   logic [1:0]  pix2;
   logic [9:0]  h1, h2;
   logic [8:0]  v1, v2;

   spi_receive_unpack #(.DATA_WIDTH(16), .LINES(6), .HRES(H1), .VRES(V1)) u_main (
      .clk_in(clk), .rst_in(rst1), .chip_data_in(data1), .chip_clk_in(dclk1),
      .chip_sel_in(cs1), .pixel_valid_out(valid1), .pixel_data_out(pix1),
      .hcount_out(h1), .vcount_out(v1), .packet_error_out(err1), .overflow_out(ovf1));

   spi_receive_unpack #(.DATA_WIDTH(2), .LINES(6)) u_fast (
      .clk_in(clk), .rst_in(rst2), .chip_data_in(data2), .chip_clk_in(dclk2),
      .chip_sel_in(cs2), .pixel_valid_out(valid2), .pixel_data_out(pix2),
      .hcount_out(h2), .vcount_out(v2), .packet_error_out(err2), .overflow_out(ovf2));

   typedef struct {
      logic [15:0] d;
      logic [9:0]  h;
      logic [8:0]  v;
   } exp_t;

   exp_t q1[$];
   exp_t q2[$];
   int n_cmp = 0, n_bad = 0;
   int err_cyc1 = 0, ovf_cyc1 = 0, err_cyc2 = 0, ovf_cyc2 = 0;
   int run1 = 0, max_run1 = 0, run2 = 0, max_run2 = 0;
   int exp_h1 = 0, exp_v1 = 0, exp_h2 = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: actual %0h required %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (err1) err_cyc1++;
      if (ovf1) ovf_cyc1++;
      run1 = valid1 ? run1 + 1 : 0;
      if (run1 > max_run1) max_run1 = run1;
      if (valid1) begin
         if (q1.size() == 0) begin
            check("unexpected_valid1", 1, 0);
         end else begin
            e = q1.pop_front();
            check("pix1_data", pix1, e.d);
            check("pix1_hcount", h1, e.h);
            check("pix1_vcount", v1, e.v);
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (err2) err_cyc2++;
      if (ovf2) ovf_cyc2++;
      run2 = valid2 ? run2 + 1 : 0;
      if (run2 > max_run2) max_run2 = run2;
      if (valid2) begin
         if (q2.size() == 0) begin
            check("unexpected_valid2", 1, 0);
         end else begin
            e = q2.pop_front();
            check("pix2_data", {14'b0, pix2}, e.d);
            check("pix2_hcount", h2, e.h);
            check("pix2_vcount", v2, e.v);
         end
      end
   end

   task automatic push1(input logic [95:0] w);
      exp_t e;
      for (int k = 0; k < 6; k++) begin
         e.d = w[k*16 +: 16];
         e.h = 10'(exp_h1);
         e.v = 9'(exp_v1);
         q1.push_back(e);
         exp_h1++;
         if (exp_h1 == H1) begin
            exp_h1 = 0;
            exp_v1++;
            if (exp_v1 == V1) exp_v1 = 0;
         end
      end
   endtask

   task automatic push2(input logic [11:0] w);
      exp_t e;
      for (int k = 0; k < 6; k++) begin
         e.d = {14'b0, w[k*2 +: 2]};
         e.h = 10'(exp_h2);
         e.v = 9'd0;
         q2.push_back(e);
         exp_h2++;
      end
   endtask

   // dclk = clk/6: three cycles low with data, three cycles high.
   task automatic spi_bit1(input logic [5:0] b);
      dclk1 = 1'b0;
      data1 = b;
      repeat (3) @(negedge clk);
      dclk1 = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic send1(input logic [95:0] w);
      logic [5:0] bits;
      for (int b = 15; b >= 0; b--) begin
         for (int k = 0; k < 6; k++) bits[k] = w[k*16 + b];
         spi_bit1(bits);
      end
   endtask

   task automatic edges1(input int n);
      repeat (n) spi_bit1(6'h2A);
   endtask

   // Overdriven dclk: low for 'low' cycles then high for one, so edges can be 2 cycles apart.
   task automatic fast_bit2(input logic [5:0] b, input int low);
      @(negedge clk);
      dclk2 = 1'b0;
      data2 = b;
      repeat (low - 1) @(negedge clk);
      @(negedge clk);
      dclk2 = 1'b1;
   endtask

   task automatic send2(input logic [11:0] w, input int low_last);
      logic [5:0] bits;
      for (int k = 0; k < 6; k++) bits[k] = w[k*2 + 1];
      fast_bit2(bits, 1);
      for (int k = 0; k < 6; k++) bits[k] = w[k*2];
      fast_bit2(bits, low_last);
   endtask

   task automatic drain1();
      int t = 0;
      while (q1.size() != 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("drain1", q1.size(), 0);
      repeat (10) @(negedge clk);
   endtask

   task automatic drain2();
      int t = 0;
      while (q2.size() != 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      check("drain2", q2.size(), 0);
      repeat (10) @(negedge clk);
   endtask

   task automatic summary();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual timeout required completion");
      n_bad++;
      summary();
      $fatal(1, "watchdog");
   end

   initial begin
      logic [95:0] w;
      rst1 = 1'b1; rst2 = 1'b1;
      cs1 = 1'b1; cs2 = 1'b1;
      dclk1 = 1'b0; dclk2 = 1'b0;
      data1 = '0; data2 = '0;
      repeat (3) @(negedge clk);
      check("rst_valid", valid1, 0);
      check("rst_data", pix1, 0);
      check("rst_hcount", h1, 0);
      check("rst_vcount", v1, 0);
      check("rst_error", err1, 0);
      check("rst_overflow", ovf1, 0);
      check("rst_valid2", valid2, 0);
      rst1 = 1'b0; rst2 = 1'b0;
      repeat (6) @(negedge clk);

      // single packet, hcount 0..5
      cs1 = 1'b0;
      repeat (4) @(negedge clk);
      w = {16'hFFFF, 16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111};
      push1(w);
      send1(w);
      repeat (4) @(negedge clk);
      cs1 = 1'b1;
      drain1();

      // dclk edges while deselected
      edges1(20);
      repeat (10) @(negedge clk);
      check("cs_high_hcount", h1, 6);
      check("cs_high_vcount", v1, 0);
      check("cs_high_errors", err_cyc1, 0);

      // aborted packet after 9 edges
      cs1 = 1'b0;
      repeat (4) @(negedge clk);
      edges1(9);
      cs1 = 1'b1;
      repeat (8) @(negedge clk);
      check("abort_error_cycles", err_cyc1, 1);
      check("abort_hcount", h1, 6);
      cs1 = 1'b0;
      repeat (4) @(negedge clk);
      w = {16'h0F0F, 16'hA5A5, 16'h8001, 16'h1234, 16'hFEDC, 16'h0000};
      push1(w);
      send1(w);
      repeat (4) @(negedge clk);
      cs1 = 1'b1;
      drain1();

      // back-to-back packets under one cs-low, through the frame wrap
      cs1 = 1'b0;
      repeat (4) @(negedge clk);
      for (int p = 0; p < 6; p++) begin
         for (int k = 0; k < 6; k++) w[k*16 +: 16] = 16'((p + 1) * 4096 + k * 273);
         push1(w);
         send1(w);
      end
      repeat (4) @(negedge clk);
      cs1 = 1'b1;
      drain1();
      check("wrap_hcount", h1, 0);
      check("wrap_vcount", v1, 0);
      check("wrap_errors", err_cyc1, 1);

      // reset mid-packet with cs held low
      cs1 = 1'b0;
      repeat (4) @(negedge clk);
      edges1(8);
      rst1 = 1'b1;
      repeat (2) @(negedge clk);
      check("midrst_valid", valid1, 0);
      check("midrst_error", err1, 0);
      rst1 = 1'b0;
      exp_h1 = 0;
      exp_v1 = 0;
      repeat (4) @(negedge clk);
      check("midrst_hcount", h1, 0);
      edges1(16);
      repeat (10) @(negedge clk);
      cs1 = 1'b1;
      repeat (6) @(negedge clk);
      check("midrst_errors", err_cyc1, 1);
      cs1 = 1'b0;
      repeat (4) @(negedge clk);
      w = {16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA, 16'hBBBB};
      push1(w);
      send1(w);
      repeat (4) @(negedge clk);
      cs1 = 1'b1;
      drain1();

      // completion 4 cycles into an emit: second packet dropped
      cs2 = 1'b0;
      repeat (4) @(negedge clk);
      push2(12'hE4D);
      send2(12'hE4D, 1);
      send2(12'h1B2, 1);
      repeat (4) @(negedge clk);
      cs2 = 1'b1;
      drain2();
      check("ovf_cycles", ovf_cyc2, 1);
      check("ovf_hcount", h2, 6);

      // completion on the last emit cycle: chained, 12 contiguous pixels
      cs2 = 1'b0;
      repeat (4) @(negedge clk);
      push2(12'h36C);
      push2(12'hC93);
      send2(12'h36C, 1);
      send2(12'hC93, 3);
      repeat (4) @(negedge clk);
      cs2 = 1'b1;
      drain2();
      check("chain_ovf_cycles", ovf_cyc2, 1);
      check("chain_hcount", h2, 18);
      check("chain_run", max_run2, 12);

      check("final_err1", err_cyc1, 1);
      check("final_ovf1", ovf_cyc1, 0);
      check("final_err2", err_cyc2, 0);
      check("final_run1", max_run1, 6);
      summary();
      $finish;
   end

endmodule
